// File: rtl/stream_mux_pkg.sv
// Shared types and the round-robin search helper for stream_mux.
// Optional packet lock is enabled with STREAM_MUX_PKT_LOCK_EN.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_t;

  localparam int MAX_N = 16;
  localparam int IDX_W = $clog2(MAX_N);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester after 'last', wrapping modulo n.
  function automatic rr_pick_t next_rr(input logic [MAX_N-1:0] valid,
                                       input logic [IDX_W-1:0] last,
                                       input int               n);
    rr_pick_t pick;
    int       cand;
    pick = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      cand = (int'(last) + k) % n;
      if (!pick.found && (k <= n) && valid[cand[IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter holding the last-grant pointer for stream_mux.
// With STREAM_MUX_PKT_LOCK_EN the grant sticks to a channel until its last beat.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic          mode_rr,
  input  logic          last_beat,
`endif
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [SW-1:0]    last_grant_q, last_grant_d;
  logic [MAX_N-1:0] req_ext;
  rr_pick_t         pick;

  assign req_ext = MAX_N'(req);

  always_comb begin
    pick = next_rr(req_ext, IDX_W'(last_grant_q), N);
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic          lock_q, lock_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;

  // A locked channel owns the grant even while it has nothing to send.
  always_comb begin
    if (lock_q) begin
      gnt_idx = lock_ch_q;
      gnt_vld = req[lock_ch_q];
    end else begin
      gnt_idx = pick.idx[SW-1:0];
      gnt_vld = pick.found;
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (!mode_rr) begin
      lock_d = 1'b0;
    end else if (advance) begin
      lock_d    = !last_beat;
      lock_ch_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  always_comb begin
    gnt_idx = pick.idx[SW-1:0];
    gnt_vld = pick.found;
  end
`endif

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) begin
      last_grant_d = gnt_idx;
    end
  end

  // Pointer starts at N-1 so the first search begins at channel 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= SW'(N - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with explicit or round-robin selection.
// Defining STREAM_MUX_PKT_LOCK_EN adds in_last/out_last and packet-locked RR grants.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]   in_last,
  output logic [0:0]     out_last,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch
);

  mode_t         mode_e;
  logic          load;
  logic          xfer;
  logic          sel_vld;
  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  ch_data [N];

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;

  assign mode_e = mode_t'(mode);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ch_data[i] = in_data[i*W +: W];
    end
  end

  // sel can exceed N-1 when N is not a power of two; that simply grants nothing.
  always_comb begin
    sel_vld = 1'b0;
    if (int'(sel) < N) begin
      sel_vld = in_valid[sel];
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [0:0] out_last_q, out_last_d;
  logic       gnt_last;

  always_comb begin
    gnt_last = in_last[gnt_idx];
  end
`endif

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (xfer && (mode_e == MODE_RR)),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .mode_rr   (mode_e == MODE_RR),
    .last_beat (gnt_last),
`endif
    .gnt_idx   (rr_idx),
    .gnt_vld   (rr_vld)
  );

  always_comb begin
    if (mode_e == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end else begin
      gnt_vld = sel_vld;
      gnt_idx = sel;
    end
  end

  // The output stage refills in the same cycle its current beat is taken.
  assign load = !out_valid_q || out_ready;
  assign xfer = load && gnt_vld;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (gnt_idx == SW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (load) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = ch_data[gnt_idx];
        out_ch_d   = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_comb begin
    out_last_d = out_last_q;
    if (xfer) begin
      out_last_d = gnt_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_last_q <= '0;
    end else begin
      out_last_q <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed self-checking bench for stream_mux (N=4, W=8).
module tb_stream_mux;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic [0:0]  out_last;
`endif

  int vectors;
  int miscompares;

  logic [7:0] exp_data [4];

  stream_mux #(.N(4), .W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_ready must never have more than one bit set.
  always @(negedge clk) begin
    vectors++;
    if (!$onehot0(in_ready)) begin
      miscompares++;
      $display("FAIL in_ready_onehot: got %b required at most one bit", in_ready);
    end
  end

  task automatic test_reset;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b d=%h ch=%0d rdy=%b required v=0 d=00 ch=0 rdy=0000",
               out_valid, out_data, out_ch, in_ready);
    end
  endtask

  task automatic test_sel;
    logic [3:0] exp_rdy;
    mode      = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    for (int s = 0; s < 4; s++) begin
      sel     = s[1:0];
      exp_rdy = 4'b0001 << s;
      @(negedge clk);
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL sel_ready[%0d]: got %b required %b", s, in_ready, exp_rdy);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_data[s] || out_ch !== s[1:0]) begin
        miscompares++;
        $display("FAIL sel_beat[%0d]: got v=%b d=%h ch=%0d required v=1 d=%h ch=%0d",
                 s, out_valid, out_data, out_ch, exp_data[s], s);
      end
    end
  endtask

  task automatic test_rr;
    int         c;
    logic [3:0] exp_rdy;
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    for (int k = 0; k < 8; k++) begin
      c       = k % 4;
      exp_rdy = 4'b0001 << c;
      @(negedge clk);
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL rr_ready[%0d]: got %b required %b", k, in_ready, exp_rdy);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_ch !== c[1:0] || out_data !== exp_data[c]) begin
        miscompares++;
        $display("FAIL rr_beat[%0d]: got v=%b ch=%0d d=%h required v=1 ch=%0d d=%h",
                 k, out_valid, out_ch, out_data, c, exp_data[c]);
      end
    end
  endtask

  task automatic test_stall;
    mode      = 1'b1;
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL stall_first_ready: got %b required 0010", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h55) begin
      miscompares++;
      $display("FAIL stall_first_beat: got v=%b ch=%0d d=%h required v=1 ch=1 d=55",
               out_valid, out_ch, out_data);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL stall_ready[%0d]: got %b required 0000", k, in_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h55) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got v=%b ch=%0d d=%h required v=1 ch=1 d=55",
                 k, out_valid, out_ch, out_data);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL stall_resume_ready: got %b required 1000", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'hFF) begin
      miscompares++;
      $display("FAIL stall_resume_beat: got v=%b ch=%0d d=%h required v=1 ch=3 d=ff",
               out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_no_grant;
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b1011;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL nogrant_ready_stalled: got %b required 0000", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF || out_ch !== 2'd3) begin
      miscompares++;
      $display("FAIL nogrant_held: got v=%b d=%h ch=%0d required v=1 d=ff ch=3",
               out_valid, out_data, out_ch);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL nogrant_ready: got %b required 0000", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'hFF || out_ch !== 2'd3) begin
      miscompares++;
      $display("FAIL nogrant_drain: got v=%b d=%h ch=%0d required v=0 d=ff ch=3",
               out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_reset_mid;
    mode      = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_ch !== k[1:0]) begin
        miscompares++;
        $display("FAIL midrst_pre[%0d]: got v=%b ch=%0d required v=1 ch=%0d",
                 k, out_valid, out_ch, k);
      end
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      miscompares++;
      $display("FAIL midrst_async: got v=%b d=%h ch=%0d required v=0 d=00 ch=0",
               out_valid, out_data, out_ch);
    end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_first_grant: got v=%b ch=%0d d=%h required v=1 ch=0 d=00",
               out_valid, out_ch, out_data);
    end
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL midrst_next_ready: got %b required 0010", in_ready);
    end
    @(posedge clk); #1;
  endtask

`ifdef STREAM_MUX_PKT_LOCK_EN
  task automatic test_pkt_lock;
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b0110;
    in_last   = 4'b0000;
    // Pointer sits at ch1 after the previous test, so ch2 would win without a lock.
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL lock_pre_ready: got %b required 0100", in_ready);
    end
    in_valid = 4'b0010;
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL lock_beat1_ready: got %b required 0010", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_ch !== 2'd1 || out_last !== 1'b0 || out_data !== 8'h55) begin
      miscompares++;
      $display("FAIL lock_beat1: got ch=%0d last=%b d=%h required ch=1 last=0 d=55",
               out_ch, out_last, out_data);
    end
    in_valid = 4'b0100;
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL lock_hold_ready: got %b required 0000", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 4'b0110;
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL lock_beat2_ready: got %b required 0010", in_ready);
    end
    @(posedge clk); #1;
    in_last = 4'b0010;
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL lock_beat3_ready: got %b required 0010", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_ch !== 2'd1 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_beat3: got ch=%0d last=%b required ch=1 last=1", out_ch, out_last);
    end
    in_last = 4'b1111;
    @(negedge clk);
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL lock_release_ready: got %b required 0100", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_ch !== 2'd2 || out_data !== 8'hAA) begin
      miscompares++;
      $display("FAIL lock_release_beat: got ch=%0d d=%h required ch=2 d=aa", out_ch, out_data);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_data[0] = 8'h00;
    exp_data[1] = 8'h55;
    exp_data[2] = 8'hAA;
    exp_data[3] = 8'hFF;
    in_data     = {8'hFF, 8'hAA, 8'h55, 8'h00};
    reset       = 1'b0;
    mode        = 1'b0;
    sel         = 2'd0;
    in_valid    = 4'b0000;
    out_ready   = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    in_last     = 4'b1111;
`endif
    #3;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    test_sel();
    test_rr();
    test_stall();
    test_no_grant();
    test_reset_mid();
`ifdef STREAM_MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
